// File: rtl/regfile_scoreboard.sv
// Integer register file with a per-register busy scoreboard for issue-time hazard detection.
// Provides combinational read ports, one write-back port, optional write-to-read bypass and flush.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_READ = 2,
    parameter int BYPASS   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_READ*ADDR_W-1:0]   rd_addr,
    output logic [NUM_READ*DATA_W-1:0]   rd_data,
    output logic [NUM_READ-1:0]          rd_ready,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         rsv_en,
    input  logic [ADDR_W-1:0]            rsv_addr,
    input  logic                         flush,
    output logic [ADDR_W:0]              busy_cnt
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_next;
    logic [ADDR_W:0]   cnt_next;

    // Priority per register: flush, then a new reservation, then write-back clear.
    always_comb begin
        busy_next = '0;
        for (int unsigned r = 1; r < DEPTH; r++) begin
            if (flush)
                busy_next[r] = 1'b0;
            else if (rsv_en && rsv_addr == ADDR_W'(r))
                busy_next[r] = 1'b1;
            else if (wr_en && wr_addr == ADDR_W'(r))
                busy_next[r] = 1'b0;
            else
                busy_next[r] = busy[r];
        end
    end

    always_comb begin
        cnt_next = '0;
        for (int unsigned r = 1; r < DEPTH; r++) begin
            cnt_next = cnt_next + (ADDR_W+1)'(busy_next[r]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            if (wr_en && wr_addr != '0)
                regs[wr_addr] <= wr_data;
            busy     <= busy_next;
            busy_cnt <= cnt_next;
        end
    end

    // regs[0] and busy[0] are never written, so index 0 reads as 0 / ready without a special case.
    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [ADDR_W-1:0] idx;
        logic              hit;

        assign idx = rd_addr[k*ADDR_W +: ADDR_W];
        assign hit = (BYPASS != 0) && wr_en && (wr_addr == idx) && (idx != '0);
        assign rd_data[k*DATA_W +: DATA_W] = hit ? wr_data : regs[idx];
        assign rd_ready[k] = hit || !busy[idx];
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: one bypassing build and two non-bypassing builds
// share the write/reservation stimulus; each has its own read addresses.
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        flush;

    logic [9:0]   rd_addr_a;
    logic [63:0]  rd_data_a;
    logic [1:0]   rd_ready_a;
    logic [5:0]   busy_cnt_a;

    logic [19:0]  rd_addr_b;
    logic [127:0] rd_data_b;
    logic [3:0]   rd_ready_b;
    logic [5:0]   busy_cnt_b;

    logic [9:0]   rd_addr_c;
    logic [63:0]  rd_data_c;
    logic [1:0]   rd_ready_c;
    logic [5:0]   busy_cnt_c;

    int errors = 0;
    int checks = 0;

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .NUM_READ(2), .BYPASS(1)) u_byp (
        .clk(clk), .rst(rst_n), .rd_addr(rd_addr_a), .rd_data(rd_data_a), .rd_ready(rd_ready_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .flush(flush), .busy_cnt(busy_cnt_a)
    );

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .NUM_READ(4), .BYPASS(0)) u_nb4 (
        .clk(clk), .rst(rst_n), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_ready(rd_ready_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .flush(flush), .busy_cnt(busy_cnt_b)
    );

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .NUM_READ(2), .BYPASS(0)) u_nb2 (
        .clk(clk), .rst(rst_n), .rd_addr(rd_addr_c), .rd_data(rd_data_c), .rd_ready(rd_ready_c),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .flush(flush), .busy_cnt(busy_cnt_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en  = 1'b0;
        rsv_en = 1'b0;
        flush  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        wr_addr = '0; wr_data = '0; rsv_addr = '0;
        rd_addr_a = {5'd7, 5'd3};
        rd_addr_b = '0;
        rd_addr_c = '0;

        // Reset state
        #12;
        check("rst_data", rd_data_a, 64'h0);
        check("rst_ready", rd_ready_a, 2'b11);
        check("rst_cnt", busy_cnt_a, 6'd0);
        @(negedge clk) rst_n = 1'b1;

        // Asynchronous reset discards a pending reservation
        tick();
        rsv_en = 1'b1; rsv_addr = 5'd5;
        tick();
        idle();
        check("arst_pre_cnt", busy_cnt_a, 6'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_cnt", busy_cnt_a, 6'd0);
        rd_addr_a = {5'd0, 5'd5};
        #1;
        check("arst_ready5", rd_ready_a[0], 1'b1);
        rst_n = 1'b1;

        // Reserve then write-back with bypass
        tick();
        rsv_en = 1'b1; rsv_addr = 5'd5;
        tick();
        idle();
        #1;
        check("rsv5_ready", rd_ready_a[0], 1'b0);
        check("rsv5_cnt", busy_cnt_a, 6'd1);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        #1;
        check("byp5_data", rd_data_a[31:0], 32'hDEADBEEF);
        check("byp5_ready", rd_ready_a[0], 1'b1);
        tick();
        idle();
        check("wb5_data", rd_data_a[31:0], 32'hDEADBEEF);
        check("wb5_ready", rd_ready_a[0], 1'b1);
        check("wb5_cnt", busy_cnt_a, 6'd0);

        // Collision: write-back and new reservation of r9 in one cycle
        rsv_en = 1'b1; rsv_addr = 5'd9;
        tick();
        idle();
        check("col_pre_cnt", busy_cnt_a, 6'd1);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h11;
        rsv_en = 1'b1; rsv_addr = 5'd9;
        tick();
        idle();
        rd_addr_a = {5'd9, 5'd9};
        #1;
        check("col_cnt", busy_cnt_a, 6'd1);
        check("col_data", rd_data_a[63:32], 32'h11);
        check("col_ready", rd_ready_a, 2'b00);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h11;
        tick();
        idle();
        check("col_clr_cnt", busy_cnt_a, 6'd0);

        // Re-reserving a busy register does not double count
        rsv_en = 1'b1; rsv_addr = 5'd7;
        tick();
        tick();
        idle();
        check("rersv_cnt", busy_cnt_a, 6'd1);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h77;
        tick();
        idle();
        check("rersv_clr_cnt", busy_cnt_a, 6'd0);

        // Flush overrides a same-cycle reservation; the same-cycle write still commits
        rsv_en = 1'b1;
        rsv_addr = 5'd1; tick();
        rsv_addr = 5'd2; tick();
        rsv_addr = 5'd3; tick();
        idle();
        check("fl_pre_cnt", busy_cnt_a, 6'd3);
        flush = 1'b1;
        rsv_en = 1'b1; rsv_addr = 5'd4;
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h5;
        tick();
        idle();
        rd_addr_a = {5'd4, 5'd2};
        #1;
        check("fl_cnt", busy_cnt_a, 6'd0);
        check("fl_data2", rd_data_a[31:0], 32'h5);
        check("fl_ready", rd_ready_a, 2'b11);

        // Register 0 ignores writes and reservations, and is never bypassed
        rd_addr_a = {5'd0, 5'd0};
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        rsv_en = 1'b1; rsv_addr = 5'd0;
        #1;
        check("r0_comb_data", rd_data_a, 64'h0);
        check("r0_comb_ready", rd_ready_a, 2'b11);
        tick();
        idle();
        check("r0_data", rd_data_a, 64'h0);
        check("r0_ready", rd_ready_a, 2'b11);
        check("r0_cnt", busy_cnt_a, 6'd0);

        // Non-bypass builds: write to non-busy r6, then reserve and write-back
        wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h13;
        tick();
        idle();
        check("nb_free_cnt", busy_cnt_b, 6'd0);
        rsv_en = 1'b1; rsv_addr = 5'd6;
        tick();
        idle();
        rd_addr_a = {5'd6, 5'd6};
        rd_addr_b = {4{5'd6}};
        rd_addr_c = {5'd6, 5'd6};
        wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h42;
        #1;
        check("nb4_ready", rd_ready_b, 4'b0000);
        check("nb4_data", rd_data_b, {4{32'h13}});
        check("nb2_ready", rd_ready_c, 2'b00);
        check("nb2_data", rd_data_c, {2{32'h13}});
        check("byp6_data", rd_data_a, {2{32'h42}});
        check("byp6_ready", rd_ready_a, 2'b11);
        tick();
        idle();
        check("nb4_wb_ready", rd_ready_b, 4'b1111);
        check("nb4_wb_data", rd_data_b, {4{32'h42}});
        check("nb2_wb_ready", rd_ready_c, 2'b11);
        check("nb2_wb_data", rd_data_c, {2{32'h42}});
        check("nb_wb_cnt", busy_cnt_c, 6'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
